sa_x_skew_feeder: RTL and testbench
===================================

Name: sa_x_skew_feeder

Overview:
- Upstream feeder for the systolic array (SA). Buffers up to N_MAX input vectors of S lanes (Q2.13, 16-bit).
- Drives the SA's x input with row skew: lane j is delayed j shift steps.
- Advances one step per SA shift pulse and generates the SA start and end flags, including a zero-filled drain phase.

Parameters:
- S, 64, number of lanes (SA rows).
- N_MAX, 64, maximum vectors per batch.
- DRAIN, 64, zero-vector steps issued after the last skewed step, before END.
- DW, 16, element width (Q2.13); fixed at 16 for SA compatibility.

Ports:
- I_CLK  in  1  clock.
- I_RST_N  in  1  reset, asynchronous, active-low.
- I_LOAD_VLD  in  1  load beat valid.
- I_LOAD_DATA  in  S*DW  one input vector; lane j at [j*DW +: DW].
- I_LOAD_LAST  in  1  marks the final vector of the batch.
- O_LOAD_RDY  out  1  ready to accept a load beat.
- I_SHIFT  in  1  SA shift pulse (SA O_SHIFT); advances one step.
- O_X  out  S*DW  skewed vector to SA I_X.
- O_START_FLAG  out  1  one-cycle pulse to SA I_START_FLAG.
- O_END_FLAG  out  1  one-cycle pulse to SA I_END_FLAG.
- O_BUSY  out  1  high in S_START and S_RUN.
- O_CNT  out  $clog2(N_MAX+1)  number of vectors in the current batch.

Behaviour:
- Reset values: O_X=0, all flags=0, O_BUSY=0, O_LOAD_RDY=0 for the reset cycle then 1 in S_LOAD, O_CNT=0. Buffer, skew lines and counters cleared.
- Async reset mid-operation returns to S_LOAD immediately and discards the batch; no END pulse is issued.
- State machine: S_LOAD -> S_START -> S_RUN -> S_LOAD.
- S_LOAD:
  - O_LOAD_RDY=1 while cnt<N_MAX.
  - Beat accepted when VLD&RDY; written to buf[cnt]; cnt++.
  - Accepted beat with LAST=1, or cnt reaching N_MAX, moves to S_START next cycle.
- S_START (one cycle):
  - O_START_FLAG=1; step counter t=0.
  - O_X presents step 0: lane 0 = buf[0][0], other lanes 0.
  - Next state S_RUN.
- S_RUN:
  - Each cycle with I_SHIFT=1 increments t; the new O_X is registered and visible the next cycle.
  - I_SHIFT is ignored outside S_RUN.
- Lane rule at step t: lane j = buf[t-j][j] if 0 <= t-j < cnt, else 0.
- Skew implementation:
  - Source vector at step t is buf[t] if t<cnt, else all-zero.
  - Lane j passes through a j-stage delay line clocked by the step advance. Lane 0 has no delay.
- Step range:
  - Skewed steps run t = 0 .. cnt+S-2.
  - Drain steps follow: t = cnt+S-1 .. cnt+S-2+DRAIN, all-zero O_X.
- Termination:
  - I_SHIFT at t = cnt+S-2+DRAIN pulses O_END_FLAG in the next cycle.
  - That same cycle: state -> S_LOAD, cnt=0, O_X=0.
- Total shift pulses consumed per batch: cnt+S-2+DRAIN+1.
- Data passes unmodified: no arithmetic, no saturation.
- Boundary conditions:
  - cnt=1 is valid.
  - LAST on beat N_MAX: single transition, no double-count.
  - VLD while RDY=0 is not accepted.
  - I_SHIFT in the S_START cycle is ignored; the SA cannot shift before it sees the start flag.
- Step counter width: $clog2(N_MAX+S+DRAIN+1).

Decomposition:
- Shared package sa_pkg:
  - DW=16, FRAC_BITS=13.
  - State encodings S_LOAD/S_START/S_RUN.
  - Q2.13 typedef; ZERO_Q constant.
- One sub-module: sa_lane_delay.
  - Parameter DEPTH; ports I_CLK, I_RST_N, I_EN, I_D[DW], O_D[DW].
  - Enable-gated shift register; DEPTH=0 is a wire.
  - Instantiated S times in a generate loop, DEPTH=j, I_EN = step advance.
  - Clear on reset and on END.

Test Plan (S=4, N_MAX=8, DRAIN=4 unless stated):
- Load 3 vectors, lane j of vector k = 16'h0100*(k+1)+j, LAST on 3rd; pulse I_SHIFT every 5 clocks.
  - Expect START one cycle after LAST.
  - O_X per step, lanes 0..3 listed: t0 = {0100,0,0,0}; t1 = {0200,0101,0,0}; t2 = {0300,0201,0102,0}; t3 = {0,0301,0202,0103}; t4 = {0,0,0302,0203}; t5 = {0,0,0,0303}; t6..t9 all zero.
  - END pulses after the 10th I_SHIFT.
- Load 8 beats without LAST.
  - O_LOAD_RDY drops after the 8th beat; START follows; O_CNT=8.
  - A 9th VLD beat is not accepted.
- Single vector {7FFF,8000,0001,FFFF}:
  - lane 3 = FFFF appears only at t=3; values pass bit-exact.
  - END after 4+4 shifts.
- I_SHIFT held high continuously in S_RUN:
  - one step per cycle; END exactly 10 cycles after the first S_RUN cycle for cnt=3.
- Assert I_RST_N low at t=2:
  - O_X=0, flags 0, O_CNT=0 immediately.
  - After release, RDY=1 and a new batch runs correctly.
- I_SHIFT pulsed in S_LOAD and in the S_START cycle:
  - no O_X change; t remains 0.

Source files
------------

// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared types and constants for the systolic-array feeder
package sa_pkg;

    localparam int DW        = 16;
    localparam int FRAC_BITS = 13;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    typedef logic [DW-1:0] q2_13_t;

    localparam q2_13_t ZERO_Q = '0;

endpackage

// File: rtl/sa_lane_delay.sv
// rtl/sa_lane_delay.sv - enable-gated per-lane delay line, DEPTH=0 is a plain wire
module sa_lane_delay #(
    parameter int DEPTH = 1,
    parameter int DW    = 16
) (
    input  logic          I_CLK,
    input  logic          I_RST_N,
    input  logic          I_EN,
    input  logic [DW-1:0] I_D,
    output logic [DW-1:0] O_D
);

    if (DEPTH == 0) begin : g_wire
        logic w_unused;
        assign w_unused = &{1'b0, I_CLK, I_RST_N, I_EN};
        assign O_D      = I_D;
    end else begin : g_sr
        logic [DW-1:0] r_sr [DEPTH];

        // shift one stage per step advance; reset empties the line
        always_ff @(posedge I_CLK or negedge I_RST_N) begin
            if (!I_RST_N) begin
                for (int k = 0; k < DEPTH; k++) r_sr[k] <= '0;
            end else if (I_EN) begin
                r_sr[0] <= I_D;
                for (int k = 1; k < DEPTH; k++) r_sr[k] <= r_sr[k-1];
            end
        end

        assign O_D = r_sr[DEPTH-1];
    end

endmodule

// File: rtl/sa_x_skew_feeder.sv
// rtl/sa_x_skew_feeder.sv - batch buffer and row-skewed x driver for the systolic array
module sa_x_skew_feeder #(
    parameter int S     = 64,
    parameter int N_MAX = 64,
    parameter int DRAIN = 64,
    parameter int DW    = 16,
    localparam int CW   = $clog2(N_MAX + 1),
    localparam int TW   = $clog2(N_MAX + S + DRAIN + 1)
) (
    input  logic            I_CLK,
    input  logic            I_RST_N,
    input  logic            I_LOAD_VLD,
    input  logic [S*DW-1:0] I_LOAD_DATA,
    input  logic            I_LOAD_LAST,
    output logic            O_LOAD_RDY,
    input  logic            I_SHIFT,
    output logic [S*DW-1:0] O_X,
    output logic            O_START_FLAG,
    output logic            O_END_FLAG,
    output logic            O_BUSY,
    output logic [CW-1:0]   O_CNT
);

    import sa_pkg::*;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [TW-1:0]   r_t;
    logic [TW-1:0]   w_last_t;
    logic [S*DW-1:0] r_buf [N_MAX];
    logic            r_end;
    logic            r_load_rdy;
    logic            w_accept;
    logic            w_adv;
    logic            w_last_step;
    logic            w_start;
    logic            w_busy;
    logic [S*DW-1:0] w_src;
    logic [S*DW-1:0] w_lane;

    assign w_accept    = (r_state == S_LOAD) && r_load_rdy && I_LOAD_VLD;
    assign w_adv       = (r_state == S_RUN) && I_SHIFT;
    // final step index: skewed steps 0..cnt+S-2 followed by DRAIN zero steps
    assign w_last_t    = TW'(r_cnt) + TW'(S + DRAIN - 2);
    assign w_last_step = (r_t == w_last_t);

    // state register
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) r_state <= S_LOAD;
        else          r_state <= w_state_nxt;
    end

    // next state, next batch count and decoded status flags
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (w_accept) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (I_LOAD_LAST || (r_cnt == CW'(N_MAX - 1))) w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_start     = 1'b1;
                w_busy      = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_adv && w_last_step) begin
                    w_state_nxt = S_LOAD;
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // batch count, step counter, registered ready and the end pulse
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_cnt      <= '0;
            r_t        <= '0;
            r_end      <= 1'b0;
            r_load_rdy <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_end      <= w_adv && w_last_step;
            r_load_rdy <= (w_state_nxt == S_LOAD) && (w_cnt_nxt < CW'(N_MAX));
            if (w_adv)                  r_t <= w_last_step ? '0 : r_t + 1'b1;
            else if (r_state == S_START) r_t <= '0;
        end
    end

    // vector buffer: accepted beat lands at the current count
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            for (int k = 0; k < N_MAX; k++) r_buf[k] <= '0;
        end else begin
            for (int k = 0; k < N_MAX; k++) begin
                if (w_accept && (r_cnt == CW'(k))) r_buf[k] <= I_LOAD_DATA;
            end
        end
    end

    // source vector for the current step: buf[t] while t<cnt, zeros afterwards
    always_comb begin
        w_src = {S{ZERO_Q}};
        for (int k = 0; k < N_MAX; k++) begin
            if ((r_t == TW'(k)) && (TW'(k) < TW'(r_cnt))) w_src = r_buf[k];
        end
    end

    // Lane j sees the source j steps late. Because the source is zero from
    // t=cnt on, the lines are guaranteed empty again by the END step; reset
    // clears them for an aborted batch.
    for (genvar j = 0; j < S; j++) begin : g_lane
        sa_lane_delay #(
            .DEPTH (j),
            .DW    (DW)
        ) u_lane_delay (
            .I_CLK   (I_CLK),
            .I_RST_N (I_RST_N),
            .I_EN    (w_adv),
            .I_D     (w_src[j*DW +: DW]),
            .O_D     (w_lane[j*DW +: DW])
        );
    end

    assign O_X          = w_busy ? w_lane : '0;
    assign O_START_FLAG = w_start;
    assign O_END_FLAG   = r_end;
    assign O_BUSY       = w_busy;
    assign O_LOAD_RDY   = r_load_rdy;
    assign O_CNT        = r_cnt;

endmodule

// File: tb/tb_sa_x_skew_feeder.sv
// tb/tb_sa_x_skew_feeder.sv - directed self-checking bench for sa_x_skew_feeder
module tb_sa_x_skew_feeder;

    localparam int S     = 4;
    localparam int N_MAX = 8;
    localparam int DRAIN = 4;
    localparam int DW    = 16;

    logic        clk;
    logic        rst_n;
    logic        load_vld;
    logic [63:0] load_data;
    logic        load_last;
    logic        load_rdy;
    logic        shift;
    logic [63:0] x;
    logic        start_flag;
    logic        end_flag;
    logic        busy;
    logic [3:0]  cnt;

    int          n_checks;
    int          n_fail;
    logic [63:0] tb_vec  [N_MAX];
    logic [63:0] exp_tab [16];

    sa_x_skew_feeder #(
        .S     (S),
        .N_MAX (N_MAX),
        .DRAIN (DRAIN),
        .DW    (DW)
    ) u_dut (
        .I_CLK        (clk),
        .I_RST_N      (rst_n),
        .I_LOAD_VLD   (load_vld),
        .I_LOAD_DATA  (load_data),
        .I_LOAD_LAST  (load_last),
        .O_LOAD_RDY   (load_rdy),
        .I_SHIFT      (shift),
        .O_X          (x),
        .O_START_FLAG (start_flag),
        .O_END_FLAG   (end_flag),
        .O_BUSY       (busy),
        .O_CNT        (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_x(input int t, input int n);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < S; j++) begin
            if ((t - j >= 0) && (t - j < n)) r[j*16 +: 16] = tb_vec[t-j][j*16 +: 16];
        end
        return r;
    endfunction

    task automatic fill_tab(input int n);
        for (int s = 0; s < 16; s++) exp_tab[s] = exp_x(s, n);
    endtask

    task automatic set_ramp_vecs();
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < S; j++)
                tb_vec[k][j*16 +: 16] = 16'(16'h0100 * (k + 1) + j);
    endtask

    task automatic load_beat(input logic [63:0] d, input logic l);
        load_vld  = 1'b1;
        load_data = d;
        load_last = l;
        @(negedge clk);
        load_vld  = 1'b0;
        load_last = 1'b0;
    endtask

    task automatic run_steps(input int n_steps, input int gap);
        for (int s = 0; s < n_steps; s++) begin
            check($sformatf("x_t%0d", s), x, exp_tab[s]);
            check($sformatf("end_lo_t%0d", s), 64'(end_flag), 64'd0);
            repeat (gap) @(negedge clk);
            shift = 1'b1;
            @(negedge clk);
            shift = 1'b0;
        end
        check("end_pulse", 64'(end_flag), 64'd1);
        check("end_busy", 64'(busy), 64'd0);
        check("end_x", x, 64'd0);
        check("end_cnt", 64'(cnt), 64'd0);
        @(negedge clk);
        check("end_once", 64'(end_flag), 64'd0);
        check("end_rdy", 64'(load_rdy), 64'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        load_vld  = 1'b0;
        load_data = '0;
        load_last = 1'b0;
        shift     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rdy", 64'(load_rdy), 64'd0);
        check("rst_x", x, 64'd0);
        check("rst_start", 64'(start_flag), 64'd0);
        check("rst_end", 64'(end_flag), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cnt", 64'(cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", 64'(load_rdy), 64'd1);

        // shift in S_LOAD must not move anything
        shift = 1'b1;
        @(negedge clk);
        shift = 1'b0;
        check("load_shift_x", x, 64'd0);
        check("load_shift_busy", 64'(busy), 64'd0);

        // three ramp vectors, shift every 5 clocks, shift during START ignored
        set_ramp_vecs();
        load_beat(tb_vec[0], 1'b0);
        load_beat(tb_vec[1], 1'b0);
        check("b1_no_start", 64'(start_flag), 64'd0);
        check("b1_cnt2", 64'(cnt), 64'd2);
        load_beat(tb_vec[2], 1'b1);
        check("b1_start", 64'(start_flag), 64'd1);
        check("b1_cnt3", 64'(cnt), 64'd3);
        check("b1_rdy_lo", 64'(load_rdy), 64'd0);
        check("b1_start_x", x, 64'h0000_0000_0000_0100);
        shift = 1'b1;
        @(negedge clk);
        shift = 1'b0;
        check("b1_start_once", 64'(start_flag), 64'd0);
        for (int s = 0; s < 16; s++) exp_tab[s] = '0;
        exp_tab[0] = 64'h0000_0000_0000_0100;
        exp_tab[1] = 64'h0000_0000_0101_0200;
        exp_tab[2] = 64'h0000_0102_0201_0300;
        exp_tab[3] = 64'h0103_0202_0301_0000;
        exp_tab[4] = 64'h0203_0302_0000_0000;
        exp_tab[5] = 64'h0303_0000_0000_0000;
        run_steps(10, 4);

        // full batch of N_MAX without LAST, 9th beat refused
        for (int k = 0; k < N_MAX; k++)
            for (int j = 0; j < S; j++)
                tb_vec[k][j*16 +: 16] = 16'(16'hA000 + 16'h0100 * k + j);
        for (int k = 0; k < N_MAX; k++) begin
            if (k == N_MAX - 1) check("b2_rdy_b8", 64'(load_rdy), 64'd1);
            load_beat(tb_vec[k], 1'b0);
        end
        check("b2_rdy_lo", 64'(load_rdy), 64'd0);
        check("b2_start", 64'(start_flag), 64'd1);
        check("b2_cnt8", 64'(cnt), 64'd8);
        load_vld  = 1'b1;
        load_data = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        load_vld  = 1'b0;
        check("b2_no_9th", 64'(cnt), 64'd8);
        check("b2_busy", 64'(busy), 64'd1);
        fill_tab(N_MAX);
        run_steps(N_MAX + S - 2 + DRAIN + 1, 0);

        // single vector with extreme values, bit-exact pass-through
        tb_vec[0] = 64'hFFFF_0001_8000_7FFF;
        load_beat(tb_vec[0], 1'b1);
        check("b3_start", 64'(start_flag), 64'd1);
        check("b3_cnt1", 64'(cnt), 64'd1);
        @(negedge clk);
        for (int s = 0; s < 16; s++) exp_tab[s] = '0;
        exp_tab[0] = 64'h0000_0000_0000_7FFF;
        exp_tab[1] = 64'h0000_0000_8000_0000;
        exp_tab[2] = 64'h0000_0001_0000_0000;
        exp_tab[3] = 64'hFFFF_0000_0000_0000;
        run_steps(8, 1);

        // asynchronous reset at t=2 aborts the batch
        set_ramp_vecs();
        load_beat(tb_vec[0], 1'b0);
        load_beat(tb_vec[1], 1'b0);
        load_beat(tb_vec[2], 1'b1);
        @(negedge clk);
        shift = 1'b1;
        repeat (2) @(negedge clk);
        shift = 1'b0;
        check("b4_pre_rst_x", x, 64'h0000_0102_0201_0300);
        rst_n = 1'b0;
        #1;
        check("b4_rst_x", x, 64'd0);
        check("b4_rst_start", 64'(start_flag), 64'd0);
        check("b4_rst_end", 64'(end_flag), 64'd0);
        check("b4_rst_cnt", 64'(cnt), 64'd0);
        check("b4_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("b4_rdy", 64'(load_rdy), 64'd1);
        check("b4_no_end", 64'(end_flag), 64'd0);

        // fresh batch after reset, shift held high: END 10 cycles into S_RUN
        load_beat(tb_vec[0], 1'b0);
        load_beat(tb_vec[1], 1'b0);
        load_beat(tb_vec[2], 1'b1);
        check("b5_start", 64'(start_flag), 64'd1);
        @(negedge clk);
        fill_tab(3);
        run_steps(10, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
